// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register carrying {pc, ir, data}
// under a valid/ready handshake, with flush for squashing wrong-path work.
//
// Handshake: a beat moves when valid & ready are both high at a rising clk
// edge; valid never depends on ready, and an offered beat (in_valid with
// in_ready low) is expected to stay stable until it is taken.
//
// SKID=1: main entry plus one skid entry, in_ready is a flop.
// SKID=0: single entry, in_ready = !out_valid | out_ready (combinational).
// Optional macro PIPE_STAGE_STAT_EN adds a saturating stall-cycle counter on
// stat_stall; without it stat_stall is tied to zero.
module pipe_stage_reg #(
  parameter int          DATA_W = 192,
  parameter int          SKID   = 1,
  parameter logic [31:0] NOP_IR = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_ir,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_ir,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       stat_stall
);

  // One atomic entry; fields always move together.
  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Value held by an invalid entry so idle outputs never show stale data.
  localparam entry_t EMPTY_ENTRY = '{pc: 32'h0, ir: NOP_IR, data: '0};

  entry_t in_entry;
  entry_t head;
  logic   in_xfer;
  logic   out_xfer;

  assign in_entry = '{pc: in_pc, ir: in_ir, data: in_data};
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  assign out_pc   = head.pc;
  assign out_ir   = head.ir;
  assign out_data = head.data;

  if (SKID != 0) begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_q;
    state_t state_d;
    entry_t main_q;
    entry_t skid_q;
    logic   ready_q;

    // Next occupancy; flush always empties, the head may still be consumed.
    always_comb begin
      state_d = state_q;
      if (flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY:   if (in_xfer) state_d = ONE;
          ONE: begin
            if (out_xfer && !in_xfer)      state_d = EMPTY;
            else if (in_xfer && !out_xfer) state_d = TWO;
          end
          TWO:     if (out_xfer) state_d = ONE;
          default: state_d = EMPTY;
        endcase
      end
    end

    // Occupancy, entry storage and the registered in_ready.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= EMPTY;
        main_q  <= EMPTY_ENTRY;
        skid_q  <= EMPTY_ENTRY;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != TWO);
        if (flush) begin
          main_q <= EMPTY_ENTRY;
          skid_q <= EMPTY_ENTRY;
        end else begin
          case (state_q)
            EMPTY: if (in_xfer) main_q <= in_entry;
            ONE: begin
              if (in_xfer && out_xfer) main_q <= in_entry;
              else if (out_xfer)       main_q <= EMPTY_ENTRY;
              else if (in_xfer)        skid_q <= in_entry;
            end
            TWO: begin
              if (out_xfer) begin
                main_q <= skid_q;
                skid_q <= EMPTY_ENTRY;
              end
            end
            default: begin
              main_q <= EMPTY_ENTRY;
              skid_q <= EMPTY_ENTRY;
            end
          endcase
        end
      end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != EMPTY);
    assign head      = main_q;
  end else begin : g_single
    logic   valid_q;
    entry_t entry_q;

    // Single entry: replace on accept, clear on consume or flush.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        entry_q <= EMPTY_ENTRY;
      end else if (flush) begin
        valid_q <= 1'b0;
        entry_q <= EMPTY_ENTRY;
      end else if (in_xfer) begin
        valid_q <= 1'b1;
        entry_q <= in_entry;
      end else if (out_xfer) begin
        valid_q <= 1'b0;
        entry_q <= EMPTY_ENTRY;
      end
    end

    assign in_ready  = !valid_q | out_ready;
    assign out_valid = valid_q;
    assign head      = entry_q;
  end

`ifdef PIPE_STAGE_STAT_EN
  logic [31:0] stall_q;

  // Count cycles where a valid head is blocked; saturates, reset-only clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'h0;
    end else if (out_valid && !out_ready && (stall_q != 32'hFFFFFFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_stall = stall_q;
`else
  assign stat_stall = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance (a_*) and a SKID=0 instance
// (b_*), each shadowed by a queue model of the stage's FIFO occupancy, plus
// directed scenarios with literal expectations.
module tb_pipe_stage_reg;
  localparam int          DW  = 192;
  localparam logic [31:0] NOP = 32'h00000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0]   a_in_pc, a_in_ir, a_out_pc, a_out_ir, a_stat;
  logic [DW-1:0] a_in_data, a_out_data;
  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0]   b_in_pc, b_in_ir, b_out_pc, b_out_ir, b_stat;
  logic [DW-1:0] b_in_data, b_out_data;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1), .NOP_IR(NOP)) u_skid (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_pc(a_in_pc), .in_ir(a_in_ir), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pc(a_out_pc), .out_ir(a_out_ir), .out_data(a_out_data),
    .stat_stall(a_stat)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(0), .NOP_IR(NOP)) u_single (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc(b_in_pc), .in_ir(b_in_ir), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_ir(b_out_ir), .out_data(b_out_data),
    .stat_stall(b_stat)
  );

  // ---------------- payload derived from pc ----------------
  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return 32'h24010001 + ((pc - 32'h3000) >> 2);
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [31:0] pc);
    return {pc, ~pc, pc + 32'd8, pc ^ 32'h5A5A5A5A, {pc[15:0], pc[31:16]}, 32'hD00D0000 + pc};
  endfunction

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural models (FIFO of pcs) ----------------
  logic [31:0] exp_q[$];    // SKID=1 stage: capacity 2
  logic [31:0] exp_b_q[$];  // SKID=0 stage: capacity 1
  logic [31:0] ma_stall, mb_stall;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    bit a_ov, a_rdy, b_ov, b_rdy;
    if (rst) begin
      exp_q.delete();
      exp_b_q.delete();
      ma_stall = 32'h0;
      mb_stall = 32'h0;
      m_live   = 1'b1;
    end else begin
      a_ov  = exp_q.size() > 0;
      a_rdy = exp_q.size() < 2;
      if (a_ov && !a_out_ready && ma_stall != 32'hFFFFFFFF) ma_stall = ma_stall + 1;
      if (a_ov && a_out_ready) void'(exp_q.pop_front());
      if (a_flush) exp_q.delete();
      else if (a_in_valid && a_rdy) exp_q.push_back(a_in_pc);

      b_ov  = exp_b_q.size() > 0;
      b_rdy = !b_ov || b_out_ready;
      if (b_ov && !b_out_ready && mb_stall != 32'hFFFFFFFF) mb_stall = mb_stall + 1;
      if (b_ov && b_out_ready) void'(exp_b_q.pop_front());
      if (b_flush) exp_b_q.delete();
      else if (b_in_valid && b_rdy) exp_b_q.push_back(b_in_pc);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0]   e_pc, e_ir, e_st;
    logic [DW-1:0] e_data;
    bit            e_v;
    if (m_live) begin
      e_v = exp_q.size() > 0;
      e_pc = 32'h0; e_ir = NOP; e_data = '0;
      if (e_v) begin e_pc = exp_q[0]; e_ir = ir_of(e_pc); e_data = data_of(e_pc); end
`ifdef PIPE_STAGE_STAT_EN
      e_st = ma_stall;
`else
      e_st = 32'h0;
`endif
      check("a_out_valid", DW'(a_out_valid), DW'(e_v));
      check("a_in_ready", DW'(a_in_ready), DW'(exp_q.size() < 2));
      check("a_out_pc", DW'(a_out_pc), DW'(e_pc));
      check("a_out_ir", DW'(a_out_ir), DW'(e_ir));
      check("a_out_data", a_out_data, e_data);
      check("a_stat_stall", DW'(a_stat), DW'(e_st));

      e_v = exp_b_q.size() > 0;
      e_pc = 32'h0; e_ir = NOP; e_data = '0;
      if (e_v) begin e_pc = exp_b_q[0]; e_ir = ir_of(e_pc); e_data = data_of(e_pc); end
`ifdef PIPE_STAGE_STAT_EN
      e_st = mb_stall;
`else
      e_st = 32'h0;
`endif
      check("b_out_valid", DW'(b_out_valid), DW'(e_v));
      check("b_in_ready", DW'(b_in_ready), DW'(!e_v || b_out_ready));
      check("b_out_pc", DW'(b_out_pc), DW'(e_pc));
      check("b_out_ir", DW'(b_out_ir), DW'(e_ir));
      check("b_out_data", b_out_data, e_data);
      check("b_stat_stall", DW'(b_stat), DW'(e_st));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic a_cycle(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    a_in_valid = iv; a_in_pc = pc; a_in_ir = ir_of(pc); a_in_data = data_of(pc);
    a_out_ready = ordy; a_flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic b_cycle(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    b_in_valid = iv; b_in_pc = pc; b_in_ir = ir_of(pc); b_in_data = data_of(pc);
    b_out_ready = ordy; b_flush = fl;
    @(posedge clk); #1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] stat5;
`ifdef PIPE_STAGE_STAT_EN
    stat5 = 32'd5;
`else
    stat5 = 32'd0;
`endif
    a_flush = 0; a_in_valid = 0; a_in_pc = 0; a_in_ir = 0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_pc = 0; b_in_ir = 0; b_in_data = '0; b_out_ready = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", DW'(a_out_valid), DW'(1'b0));
    check("rst_out_ir", DW'(a_out_ir), DW'(32'h0));
    check("rst_out_pc", DW'(a_out_pc), DW'(32'h0));
    check("rst_in_ready", DW'(a_in_ready), DW'(1'b1));

    // streaming, no gaps
    a_cycle(1, 32'h3000, 1, 0);
    check("stream0_pc", DW'(a_out_pc), DW'(32'h3000));
    check("stream0_ir", DW'(a_out_ir), DW'(32'h24010001));
    a_cycle(1, 32'h3004, 1, 0);
    check("stream1_pc", DW'(a_out_pc), DW'(32'h3004));
    check("stream1_ready", DW'(a_in_ready), DW'(1'b1));
    a_cycle(1, 32'h3008, 1, 0);
    check("stream2_ir", DW'(a_out_ir), DW'(32'h24010003));
    check("stream2_data_hi", DW'(a_out_data[DW-1 -: 32]), DW'(32'h3008));
    a_cycle(0, 32'h0, 1, 0);
    check("stream_idle_valid", DW'(a_out_valid), DW'(1'b0));

    // backpressure into the skid entry
    a_cycle(1, 32'h3000, 0, 0);
    check("bp_one_ready", DW'(a_in_ready), DW'(1'b1));
    a_cycle(1, 32'h3004, 0, 0);
    check("bp_two_ready", DW'(a_in_ready), DW'(1'b0));
    check("bp_two_pc", DW'(a_out_pc), DW'(32'h3000));
    a_cycle(1, 32'h3008, 0, 0);
    check("bp_hold_pc", DW'(a_out_pc), DW'(32'h3000));
    a_cycle(1, 32'h3008, 1, 0);
    check("bp_drain1_pc", DW'(a_out_pc), DW'(32'h3004));
    check("bp_drain1_ready", DW'(a_in_ready), DW'(1'b1));
    a_cycle(1, 32'h3008, 1, 0);
    check("bp_drain2_pc", DW'(a_out_pc), DW'(32'h3008));
    a_cycle(0, 32'h0, 1, 0);
    check("bp_empty", DW'(a_out_valid), DW'(1'b0));

    // flush from TWO with a same-cycle input
    a_cycle(1, 32'h3000, 0, 0);
    a_cycle(1, 32'h3004, 0, 0);
    a_cycle(1, 32'h3008, 0, 1);
    check("flush_valid", DW'(a_out_valid), DW'(1'b0));
    check("flush_ir", DW'(a_out_ir), DW'(NOP));
    check("flush_ready", DW'(a_in_ready), DW'(1'b1));
    a_cycle(0, 32'h0, 1, 0);
    check("flush_dropped", DW'(a_out_valid), DW'(1'b0));
    a_cycle(1, 32'h300C, 1, 0);
    a_cycle(1, 32'h3010, 1, 1);
    check("flush_consume_valid", DW'(a_out_pc), DW'(32'h0));
    a_cycle(0, 32'h0, 1, 0);

    // single-entry build: combinational in_ready, replacement without bubble
    b_cycle(1, 32'h3000, 0, 0);
    check("b_held_pc", DW'(b_out_pc), DW'(32'h3000));
    b_in_valid = 1; b_in_pc = 32'h3004; b_in_ir = ir_of(32'h3004); b_in_data = data_of(32'h3004);
    b_out_ready = 0;
    #1;
    check("b_ready_low", DW'(b_in_ready), DW'(1'b0));
    b_out_ready = 1;
    #1;
    check("b_ready_high", DW'(b_in_ready), DW'(1'b1));
    @(posedge clk); #1;
    check("b_replace_pc", DW'(b_out_pc), DW'(32'h3004));
    check("b_replace_valid", DW'(b_out_valid), DW'(1'b1));
    b_cycle(0, 32'h0, 1, 0);
    check("b_drained", DW'(b_out_valid), DW'(1'b0));
    b_cycle(1, 32'h3020, 0, 1);
    check("b_flush_drop", DW'(b_out_valid), DW'(1'b0));

    // stall counter
    rst = 1'b1;
    a_cycle(0, 32'h0, 0, 0);
    rst = 1'b0;
    check("stat_after_rst", DW'(a_stat), DW'(32'h0));
    a_cycle(1, 32'h3000, 0, 0);
    repeat (5) a_cycle(0, 32'h0, 0, 0);
    check("stat_five", DW'(a_stat), DW'(stat5));
    a_cycle(0, 32'h0, 1, 1);
    check("stat_after_flush", DW'(a_stat), DW'(stat5));
    rst = 1'b1;
    a_cycle(0, 32'h0, 0, 0);
    rst = 1'b0;
    check("stat_cleared", DW'(a_stat), DW'(32'h0));
    a_cycle(0, 32'h0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
